uart_tx_framer: RTL and testbench

- Parametrised UART transmit framer and successor to the fixed-character transmitter.
- Accepts arbitrary data words over a valid/ready handshake and serialises them LSB-first.
- Configurable data width, parity mode and stop-bit count; baud divisor is derived from clock and baud parameters.
- Sits between the button/event logic or a future TX FIFO and the board TX pin; reports per-frame completion.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_tx_framer.sv | 138 +++++++++++++
 tb/tb_uart_tx_framer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and the
// frame-length / baud-divisor helpers used by the TX framer and the future RX deframer.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Line bits per frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned width,
                                             input int unsigned parity,
                                             input int unsigned stop);
    int unsigned par_bits;
    par_bits = (parity != PARITY_NONE) ? 32'd1 : 32'd0;
    return 32'd1 + width + par_bits + stop;
  endfunction

  // Clock cycles per line bit (integer divide).
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator.
//   clk_i    : clock
//   rst_n_i  : synchronous active-low reset
//   en_i     : count while high; counter held at 0 while low
//   clr_i    : restart the bit period from 0
//   tick_c_o : combinational pulse on the last cycle of each BAUD_DIV-cycle period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c_o = en_i && (cnt_q == CNT_MAX);

  // Wrap on tick so every period is exactly BAUD_DIV cycles; no drift across frames.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || !en_i || tick_c_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word over valid/ready and sends
// start, data (LSB first), optional parity and stop bit(s) on tx.
//   sysclk   : clock
//   rst_n    : synchronous active-low reset
//   in_data  : word to transmit
//   in_valid : in_data valid
//   in_ready : framer can accept a word this cycle (combinational)
//   busy     : frame in progress
//   tx_done  : one-cycle pulse when the last stop bit completes
//   tx       : serial line, idle high
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 125000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx
);

  localparam int unsigned BAUD_DIV   = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned FRAME_BITS = frame_bits(DATA_WIDTH, PARITY, STOP_BITS);
  localparam int unsigned SH_W       = FRAME_BITS - 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_framer: BAUD_DIV must be >= 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_framer: DATA_WIDTH must be 5..9");
  end
  if (PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end

  state_e           state_q, state_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic             tx_q,    tx_d;
  logic             done_q,  done_d;

  logic             accept_c;
  logic             tick_c;
  logic [SH_W-1:0]  load_c;

  assign in_ready = (state_q == IDLE) && rst_n;
  assign busy     = (state_q == SEND);
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign accept_c = in_valid && in_ready;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk_i    (sysclk),
    .rst_n_i  (rst_n),
    .en_i     (state_q == SEND),
    .clr_i    (accept_c),
    .tick_c_o (tick_c)
  );

  // Everything after the start bit, in line order; the 1-fill above the
  // parity position supplies the stop bit(s).
  always_comb begin
    load_c                 = '1;
    load_c[DATA_WIDTH-1:0] = in_data;
    if (PARITY == PARITY_EVEN) begin
      load_c[DATA_WIDTH] = ^in_data;
    end else if (PARITY == PARITY_ODD) begin
      load_c[DATA_WIDTH] = ~(^in_data);
    end
  end

  // Next-state and output logic; bit_q is the index of the bit currently on tx.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        bit_d = '0;
        if (accept_c) begin
          state_d = SEND;
          shift_d = load_c;
          tx_d    = 1'b0;
        end
      end
      SEND: begin
        if (tick_c) begin
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[SH_W-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer at BAUD_DIV = 16 in four configurations
// (8N1, 8E1, 8O1, 7O2). Stimulus pushes expected frames; a monitor decodes tx.
module tb_uart_tx_framer;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] in_data;
  logic       in_valid;
  logic [1:0] sel;
  logic [3:0] rdy, bsy, done, txs;
  logic       mtx, mbusy, mdone, mrdy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  frame_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_framer #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sysclk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid && (sel == 2'd0)),
    .in_ready(rdy[0]), .busy(bsy[0]), .tx_done(done[0]), .tx(txs[0]));
  uart_tx_framer #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .sysclk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid && (sel == 2'd1)),
    .in_ready(rdy[1]), .busy(bsy[1]), .tx_done(done[1]), .tx(txs[1]));
  uart_tx_framer #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .sysclk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid && (sel == 2'd2)),
    .in_ready(rdy[2]), .busy(bsy[2]), .tx_done(done[2]), .tx(txs[2]));
  uart_tx_framer #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_WIDTH(7), .PARITY(2), .STOP_BITS(2)) u_7o2 (
    .sysclk(clk), .rst_n(rst_n), .in_data(in_data[6:0]), .in_valid(in_valid && (sel == 2'd3)),
    .in_ready(rdy[3]), .busy(bsy[3]), .tx_done(done[3]), .tx(txs[3]));

  assign mtx   = txs[sel];
  assign mbusy = bsy[sel];
  assign mdone = done[sel];
  assign mrdy  = rdy[sel];

  // Reference frame: start 0, data LSB first, parity, stop ones.
  function automatic frame_t mk(input logic [8:0] d, input int w, input int par, input int stop);
    frame_t f;
    logic   p;
    int     idx;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    p         = 1'b0;
    for (int i = 0; i < w; i++) begin
      f.bits[1+i] = d[i];
      p           = p ^ d[i];
    end
    idx = 1 + w;
    if (par != 0) begin
      f.bits[idx] = (par == 1) ? p : ~p;
      idx++;
    end
    f.n = idx + stop;
    return f;
  endfunction

  // Monitor: collects tx samples from start bit until tx_done, then scores the frame.
  initial begin : monitor
    logic   samp [0:255];
    int     cnt, bcnt, err;
    bit     act;
    frame_t e;
    act  = 1'b0;
    cnt  = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
      end else if (mdone) begin
        total++;
        if (!act || exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done t=%0t sel=%0d in_frame=%0d queued=%0d", $time, sel, act, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          total++;
          if (cnt != e.n * DIV || bcnt != e.n * DIV) begin
            bad++;
            $display("FAIL frame_len sel=%0d got tx_cycles=%0d busy_cycles=%0d want %0d", sel, cnt, bcnt, e.n * DIV);
          end
          err = -1;
          for (int i = 0; i < e.n * DIV && i < cnt && i < 256; i++) begin
            if (err < 0 && samp[i] !== e.bits[i / DIV]) err = i;
          end
          total++;
          if (err >= 0) begin
            bad++;
            $display("FAIL frame_bits sel=%0d cycle=%0d bit=%0d got %0b want %0b", sel, err, err / DIV, samp[err], e.bits[err / DIV]);
          end
          total++;
          if (mrdy !== 1'b1 || mbusy !== 1'b0 || mtx !== 1'b1) begin
            bad++;
            $display("FAIL done_cycle sel=%0d got ready=%0b busy=%0b tx=%0b want 1 0 1", sel, mrdy, mbusy, mtx);
          end
        end
        act = 1'b0;
      end else begin
        if (!act && mtx == 1'b0) begin
          act  = 1'b1;
          cnt  = 0;
          bcnt = 0;
        end
        if (act) begin
          if (cnt < 256) samp[cnt] = mtx;
          cnt++;
          if (mbusy) bcnt++;
        end
      end
    end
  end

  task automatic send(input logic [8:0] d, input bit drop);
    int t;
    @(posedge clk); #2;
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mrdy && t < 2000);
    total++;
    if (!mrdy) begin
      bad++;
      $display("FAIL accept_timeout sel=%0d got ready=0 want 1", sel);
    end
    @(posedge clk); #2;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mdone && t < 3000);
    total++;
    if (!mdone) begin
      bad++;
      $display("FAIL done_timeout sel=%0d got tx_done=0 want 1", sel);
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin : stim
    int idle_bad;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sel      = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx",    {4'h0, txs},  8'h0F);
    check("reset_busy",  {4'h0, bsy},  8'h00);
    check("reset_done",  {4'h0, done}, 8'h00);
    check("reset_ready", {4'h0, rdy},  8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {4'h0, rdy}, 8'h0F);

    // 8N1, 8E1, 8O1 with 0x41; 7O2 with 0x55
    sel = 2'd0; exp_q.push_back(mk(9'h041, 8, 0, 1)); send(9'h041, 1'b1); wait_done();
    @(posedge clk); #2;
    sel = 2'd1; exp_q.push_back(mk(9'h041, 8, 1, 1)); send(9'h041, 1'b1); wait_done();
    @(posedge clk); #2;
    sel = 2'd2; exp_q.push_back(mk(9'h041, 8, 2, 1)); send(9'h041, 1'b1); wait_done();
    @(posedge clk); #2;
    sel = 2'd3; exp_q.push_back(mk(9'h055, 7, 2, 2)); send(9'h055, 1'b1); wait_done();
    @(posedge clk); #2;

    // Back-to-back with in_valid held; in_data churns during the first frame
    sel = 2'd0;
    exp_q.push_back(mk(9'h0A5, 8, 0, 1));
    exp_q.push_back(mk(9'h03C, 8, 0, 1));
    send(9'h0A5, 1'b0);
    in_data = 9'h0FF;
    repeat (60) @(posedge clk);
    #2 in_data = 9'h000;
    repeat (60) @(posedge clk);
    #2 in_data = 9'h03C;
    wait_done();
    check("gap_idle_high", {7'h0, mtx}, 8'h01);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_start", {6'h0, mtx, mbusy}, 8'h01);
    wait_done();
    @(posedge clk); #2;

    // Reset in the middle of data bit 4 of 0xFF
    send(9'h0FF, 1'b1);
    repeat (5 * DIV + 8) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("mid_reset", {4'h0, mtx, mbusy, mrdy, mdone}, 8'h08);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_q.push_back(mk(9'h000, 8, 0, 1));
    send(9'h000, 1'b1);
    wait_done();

    // Idle: nothing requested for 500 cycles
    idle_bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (mtx !== 1'b1 || mdone !== 1'b0 || mrdy !== 1'b1) idle_bad++;
    end
    check("idle_500", 8'(idle_bad), 8'h00);

    repeat (5) @(posedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got no finish want finish by 2000000");
    $fatal(1, "watchdog");
  end

endmodule
